// File: rtl/logic_calc_sequencer.sv
// Bit-serial logic unit: runs WIDTH-bit AND/OR/NOT through one 1-bit
// calculator, LSB first, with valid/ready handshakes on both sides.

module basic_logic_calculator (
  input  logic       a,
  input  logic       b,
  input  logic [1:0] s,
  output logic       result
);

  always_comb begin
    result = 1'b0;
    unique case (s)
      2'b00: result = a & b;
      2'b01: result = a | b;
      2'b10: result = ~a;
      2'b11: result = ~b;
      default: result = 1'b0;
    endcase
  end

endmodule

module logic_calc_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_nx;
  logic [WIDTH-1:0] data_r;
  logic [1:0]       op_r;
  logic [CW-1:0]    cnt;
  logic             result;
  logic             last;

  basic_logic_calculator u_calc (
    .a      (a_sh[0]),
    .b      (b_sh[0]),
    .s      (op_r),
    .result (result)
  );

  // Truncation keeps {result, res_sh[WIDTH-1:1]}, valid even for WIDTH=1
  assign res_nx = WIDTH'({result, res_sh} >> 1);
  assign last   = (cnt == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: if (in_valid)  state_nx = RUN;
      RUN:  if (last)      state_nx = DONE;
      DONE: if (out_ready) state_nx = IDLE;
      default:             state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      op_r   <= 2'b00;
      res_sh <= '0;
      cnt    <= '0;
      data_r <= '0;
    end else if (state == IDLE) begin
      if (in_valid) begin
        a_sh <= in_a;
        b_sh <= in_b;
        op_r <= in_op;
        cnt  <= '0;
      end
    end else if (state == RUN) begin
      a_sh   <= a_sh >> 1;
      b_sh   <= b_sh >> 1;
      res_sh <= res_nx;
      if (last) data_r <= res_nx;
      else      cnt    <= cnt + CW'(1);
    end
  end

  assign in_ready  = (state == IDLE);
  assign busy      = (state != IDLE);
  assign out_valid = (state == DONE);
  assign out_data  = data_r;

endmodule

// File: tb/tb_logic_calc_sequencer.sv
// Bench for logic_calc_sequencer: directed vectors, corner sequences and
// random traffic against a word-level model, on WIDTH=8 and WIDTH=1 builds.

module tb_logic_calc_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_a = '0;
  logic [7:0] in_b = '0;
  logic [1:0] in_op = '0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       busy;

  logic       v1 = 1'b0;
  logic       r1;
  logic [0:0] a1 = '0;
  logic [0:0] b1 = '0;
  logic [1:0] op1 = '0;
  logic       ov1;
  logic       or1 = 1'b0;
  logic [0:0] d1;
  logic       busy1;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  logic_calc_sequencer #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .busy(busy)
  );

  logic_calc_sequencer #(.WIDTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(v1), .in_ready(r1),
    .in_a(a1), .in_b(b1), .in_op(op1),
    .out_valid(ov1), .out_ready(or1),
    .out_data(d1), .busy(busy1)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [1:0] op;
    logic [7:0] exp;
  } vec_t;

  function automatic logic [7:0] model(input logic [7:0] a, b,
                                       input logic [1:0] op);
    case (op)
      2'b00:   return a & b;
      2'b01:   return a | b;
      2'b10:   return ~a;
      default: return ~b;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full transaction on the 8-bit DUT, starting at a negedge
  task automatic do_op(input logic [7:0] a, b, input logic [1:0] op,
                       input bit early, output logic [7:0] res,
                       output int lat, output bit rdy_low);
    in_a = a; in_b = b; in_op = op;
    in_valid = 1'b1;
    out_ready = early;
    chk("in_ready_before", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_a = ~a; in_b = ~b; in_op = ~op;
    lat = 0;
    rdy_low = 1;
    while (lat < 50) begin
      if (in_ready) rdy_low = 0;
      @(posedge clk);
      @(negedge clk);
      lat++;
      if (out_valid) break;
    end
    res = out_data;
    out_ready = 1'b1;
    if (in_ready) rdy_low = 0;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("in_ready_after_hs", in_ready, 1);
    chk("out_valid_after_hs", out_valid, 0);
  endtask

  vec_t vt[5];

  initial begin
    logic [7:0] res;
    logic [7:0] held;
    int lat;
    bit rl;

    vt[0] = '{a: 8'hF0, b: 8'h3C, op: 2'b00, exp: 8'h30};
    vt[1] = '{a: 8'hA5, b: 8'h0F, op: 2'b01, exp: 8'hAF};
    vt[2] = '{a: 8'h5A, b: 8'h33, op: 2'b10, exp: 8'hA5};
    vt[3] = '{a: 8'hFF, b: 8'h00, op: 2'b11, exp: 8'hFF};
    vt[4] = '{a: 8'h0C, b: 8'h96, op: 2'b01, exp: 8'h9E};

    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_w1_data", d1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      do_op(vt[i].a, vt[i].b, vt[i].op, 1'b0, res, lat, rl);
      chk($sformatf("vec%0d_data", i), res, vt[i].exp);
      chk($sformatf("vec%0d_latency", i), lat, 8);
      chk($sformatf("vec%0d_ready_low", i), rl, 1);
    end

    // Backpressure with an ignored request in DONE
    in_a = 8'h12; in_b = 8'h34; in_op = 2'b01; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);
    chk("bp_valid_rise", out_valid, 1);
    held = out_data;
    chk("bp_data", held, 8'h36);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i == 2);
      in_a = 8'hFF; in_b = 8'hFF; in_op = 2'b00;
      @(negedge clk);
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, held);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("bp_no_queue_busy", busy, 0);
    end
    chk("bp_data_kept", out_data, held);

    // Reset aborts a run in progress
    in_a = 8'h0F; in_b = 8'hF0; in_op = 2'b01; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_busy_pre", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    do_op(8'hFF, 8'h01, 2'b00, 1'b0, res, lat, rl);
    chk("post_rst_data", res, 8'h01);
    chk("post_rst_latency", lat, 8);

    // Random traffic; some runs keep out_ready high from acceptance
    for (int i = 0; i < 40; i++) begin
      logic [7:0] ra;
      logic [7:0] rb;
      logic [1:0] ro;
      ra = 8'($urandom);
      rb = 8'($urandom);
      ro = 2'($urandom_range(0, 3));
      do_op(ra, rb, ro, bit'($urandom_range(0, 1)), res, lat, rl);
      chk($sformatf("rnd%0d_data", i), res, model(ra, rb, ro));
      chk($sformatf("rnd%0d_latency", i), lat, 8);
    end

    // WIDTH=1 build, every opcode
    for (int op = 0; op < 4; op++) begin
      int n;
      logic [0:0] exp1;
      exp1 = model(8'h01, 8'h00, 2'(op)) & 8'h01;
      a1 = 1'b1; b1 = 1'b0; op1 = 2'(op); v1 = 1'b1;
      chk("w1_in_ready", r1, 1);
      @(posedge clk);
      @(negedge clk);
      v1 = 1'b0;
      n = 0;
      while (n < 20) begin
        @(posedge clk);
        @(negedge clk);
        n++;
        if (ov1) break;
      end
      chk($sformatf("w1_op%0d_data", op), d1, exp1);
      chk($sformatf("w1_op%0d_latency", op), n, 1);
      or1 = 1'b1;
      @(negedge clk);
      or1 = 1'b0;
      chk("w1_ready_after", r1, 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
